// File: rtl/scmp_bus_ctl_pkg.sv
// Shared types for the SC/MP external bus controller: cycle states, ADS flag
// bit positions and the helper that builds the byte driven on D during ADS.
package scmp_bus_ctl_pkg;

  typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, DONE} BUS_ST_t;

  // Positions of the {H,D,I,R} cycle flags in cpu_flags and in D[7:4] at ADS
  localparam int BUS_FLAG_IX_H = 3;
  localparam int BUS_FLAG_IX_D = 2;
  localparam int BUS_FLAG_IX_I = 1;
  localparam int BUS_FLAG_IX_R = 0;

  function automatic logic [7:0] ads_byte(input logic [3:0] flags, input logic [3:0] a_hi);
    return {flags, a_hi};
  endfunction

endpackage

// File: rtl/scmp_bus_ctl_if.sv
// Core-side request and system-bus pin bundle. The slave modport is the
// controller's view; the master modport is the core/pin environment's view.
interface scmp_bus_ctl_if;
  logic        cpu_req;
  logic        cpu_wr;
  logic [15:0] cpu_addr;
  logic [3:0]  cpu_flags;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_err;
  logic        breq_o;
  logic        enin;
  logic        enout;
  logic        hold;
  logic [11:0] addr;
  logic [7:0]  D_i;
  logic [7:0]  D_o;
  logic        D_oe;
  logic        ADS_n;
  logic        RD_n;
  logic        WR_n;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_flags, cpu_wdata, enin, hold, D_i,
    output cpu_rdata, cpu_ack, cpu_err, breq_o, enout, addr, D_o, D_oe, ADS_n, RD_n, WR_n
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_flags, cpu_wdata, enin, hold, D_i,
    input  cpu_rdata, cpu_ack, cpu_err, breq_o, enout, addr, D_o, D_oe, ADS_n, RD_n, WR_n
  );
endinterface

// File: rtl/scmp_bus_wait_cnt.sv
// Data-strobe length counter plus, with SCMP_BUS_TIMEOUT_EN, a counter of
// HOLD-extended cycles that flags a timeout once TIMEOUT extensions have run.
module scmp_bus_wait_cnt #(
  parameter int DATA_CYCLES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_dec,
  input  logic i_ext,
  output logic o_last,
  output logic o_timeout
);
  localparam int CW = (DATA_CYCLES > 1) ? $clog2(DATA_CYCLES) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)                    r_cnt <= '0;
    else if (i_load)               r_cnt <= CW'(DATA_CYCLES - 1);
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_last = (r_cnt == '0);

`ifdef SCMP_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_tcnt;

  always_ff @(posedge clk) begin
    if (!rst_n)      r_tcnt <= '0;
    else if (i_load) r_tcnt <= '0;
    else if (i_ext)  r_tcnt <= r_tcnt + 1'b1;
  end

  assign o_timeout = (r_tcnt == TW'(TIMEOUT));
`else
  logic [31:0] w_unused;
  assign w_unused  = {31'(TIMEOUT), i_ext};
  assign o_timeout = 1'b0;
`endif

endmodule

// File: rtl/scmp_bus_ctl.sv
// SC/MP external bus cycle controller: BREQ/ENIN arbitration, ADS/RD/WR strobes
// and HOLD wait states. Optional HOLD timeout abort under SCMP_BUS_TIMEOUT_EN.
module scmp_bus_ctl
  import scmp_bus_ctl_pkg::*;
#(
  parameter int DATA_CYCLES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  scmp_bus_ctl_if.slave  bus
);
  BUS_ST_t     r_state, w_nxt;
  logic        r_wr;
  logic [15:0] r_addr;
  logic [3:0]  r_flags;
  logic [7:0]  r_wdata;

  logic        r_ads_n, r_rd_n, r_wr_n, r_breq, r_doe, r_ack, r_err;
  logic        w_ads_n, w_rd_n, w_wr_n, w_breq, w_doe, w_ack, w_err;
  logic [11:0] r_pin_addr, w_pin_addr;
  logic [7:0]  r_do, w_do, r_rdata, w_rdata;
  logic        w_latch, w_last, w_tmo;

  scmp_bus_wait_cnt #(.DATA_CYCLES(DATA_CYCLES), .TIMEOUT(TIMEOUT)) u_wait (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (r_state == ADDR),
    .i_dec     (r_state == DATA),
    .i_ext     ((r_state == DATA) && w_last && bus.hold),
    .o_last    (w_last),
    .o_timeout (w_tmo)
  );

  // Payload is taken only when a new cycle is accepted, from IDLE or as a retained-bus restart
  assign w_latch = (r_state == IDLE && bus.cpu_req) ||
                   (r_state == DONE && bus.cpu_req && bus.enin);

  // Outputs are computed for the next state and registered, so pins line up with r_state
  always_comb begin
    w_nxt      = r_state;
    w_ads_n    = 1'b1;
    w_rd_n     = 1'b1;
    w_wr_n     = 1'b1;
    w_doe      = 1'b0;
    w_do       = r_do;
    w_pin_addr = r_pin_addr;
    w_breq     = r_breq;
    w_ack      = 1'b0;
    w_err      = 1'b0;
    w_rdata    = r_rdata;
    unique case (r_state)
      IDLE: if (bus.cpu_req) begin
        w_nxt  = REQ;
        w_breq = 1'b1;
      end
      REQ: if (bus.enin) begin
        w_nxt      = ADDR;
        w_ads_n    = 1'b0;
        w_pin_addr = r_addr[11:0];
        w_do       = ads_byte(r_flags, r_addr[15:12]);
        w_doe      = 1'b1;
      end
      ADDR: begin
        w_nxt  = DATA;
        w_rd_n = r_wr;
        w_wr_n = !r_wr;
        if (r_wr) begin
          w_do  = r_wdata;
          w_doe = 1'b1;
        end
      end
      DATA: begin
        if (w_last && !bus.hold) begin
          w_nxt   = DONE;
          w_ack   = 1'b1;
          w_rdata = r_wr ? r_rdata : bus.D_i;
        end else if (w_last && w_tmo) begin
          w_nxt   = DONE;
          w_ack   = 1'b1;
          w_err   = 1'b1;
          w_rdata = r_wr ? r_rdata : 8'hFF;
        end else begin
          w_rd_n = r_wr;
          w_wr_n = !r_wr;
          if (r_wr) begin
            w_do  = r_wdata;
            w_doe = 1'b1;
          end
        end
      end
      DONE: if (bus.cpu_req && bus.enin) begin
        w_nxt      = ADDR;
        w_ads_n    = 1'b0;
        w_pin_addr = bus.cpu_addr[11:0];
        w_do       = ads_byte(bus.cpu_flags, bus.cpu_addr[15:12]);
        w_doe      = 1'b1;
      end else begin
        w_nxt  = IDLE;
        w_breq = 1'b0;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_flags    <= '0;
      r_wdata    <= '0;
      r_ads_n    <= 1'b1;
      r_rd_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_breq     <= 1'b0;
      r_doe      <= 1'b0;
      r_do       <= '0;
      r_pin_addr <= '0;
      r_rdata    <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_ads_n    <= w_ads_n;
      r_rd_n     <= w_rd_n;
      r_wr_n     <= w_wr_n;
      r_breq     <= w_breq;
      r_doe      <= w_doe;
      r_do       <= w_do;
      r_pin_addr <= w_pin_addr;
      r_rdata    <= w_rdata;
      r_ack      <= w_ack;
      r_err      <= w_err;
      if (w_latch) begin
        r_wr    <= bus.cpu_wr;
        r_addr  <= bus.cpu_addr;
        r_flags <= bus.cpu_flags;
        r_wdata <= bus.cpu_wdata;
      end
    end
  end

  assign bus.enout     = bus.enin && (r_state == IDLE);
  assign bus.ADS_n     = r_ads_n;
  assign bus.RD_n      = r_rd_n;
  assign bus.WR_n      = r_wr_n;
  assign bus.breq_o    = r_breq;
  assign bus.D_oe      = r_doe;
  assign bus.D_o       = r_do;
  assign bus.addr      = r_pin_addr;
  assign bus.cpu_rdata = r_rdata;
  assign bus.cpu_ack   = r_ack;
  assign bus.cpu_err   = r_err;

endmodule

// File: tb/tb_scmp_bus_ctl.sv
// Directed bench for scmp_bus_ctl: read/write timing, HOLD, arbitration wait,
// retained-bus back-to-back, mid-cycle reset and (SCMP_BUS_TIMEOUT_EN) timeout.
module tb_scmp_bus_ctl;
`ifdef SCMP_BUS_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scmp_bus_ctl_if bus();

  scmp_bus_ctl #(.DATA_CYCLES(2), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int ads_cnt, ads_first, ads_last, rd_cnt, rd_doe_bad, wr_cnt, wr_bad;
  int ack_cnt, ack_first, ack_last, breq_drop, enout_busy;
  logic [11:0] ads_addr;
  logic [7:0]  ads_do, rdata_at_ack;
  logic        ads_doe, err_at_ack;

  task automatic start(input logic wr, input logic [15:0] a, input logic [3:0] f, input logic [7:0] wd);
    @(negedge clk);
    bus.cpu_wr    = wr;
    bus.cpu_addr  = a;
    bus.cpu_flags = f;
    bus.cpu_wdata = wd;
    bus.cpu_req   = 1'b1;
  endtask

  // Observes cycles 1..ncyc after the request is sampled; k is the cycle number
  task automatic watch(input int ncyc, input int n_acks, input int h_from, input int h_to,
                       input int en_from, input logic [7:0] wd_exp, input bit scramble);
    ads_cnt = 0; ads_first = 0; ads_last = 0; rd_cnt = 0; rd_doe_bad = 0; wr_cnt = 0; wr_bad = 0;
    ack_cnt = 0; ack_first = 0; ack_last = 0; breq_drop = 0; enout_busy = 0;
    ads_addr = '0; ads_do = '0; ads_doe = 1'b0; rdata_at_ack = '0; err_at_ack = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (!bus.ADS_n) begin
        ads_cnt++;
        if (ads_first == 0) ads_first = k;
        ads_last = k; ads_addr = bus.addr; ads_do = bus.D_o; ads_doe = bus.D_oe;
      end
      if (!bus.RD_n) begin rd_cnt++; if (bus.D_oe) rd_doe_bad++; end
      if (!bus.WR_n) begin wr_cnt++; if (!bus.D_oe || bus.D_o !== wd_exp) wr_bad++; end
      if (ack_cnt < n_acks) begin
        if (!bus.breq_o) breq_drop++;
        if (bus.enout) enout_busy++;
      end
      if (bus.cpu_ack) begin
        ack_cnt++;
        if (ack_first == 0) ack_first = k;
        ack_last = k; err_at_ack = bus.cpu_err; rdata_at_ack = bus.cpu_rdata;
        if (ack_cnt >= n_acks) bus.cpu_req = 1'b0;
      end
      if (k == 1 && scramble) begin
        bus.cpu_addr = 16'hFFFF; bus.cpu_wdata = 8'h00; bus.cpu_flags = 4'h0;
      end
      bus.hold = (k >= h_from && k <= h_to);
      bus.enin = (k >= en_from);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({bus.ADS_n, bus.RD_n, bus.WR_n} !== 3'b111) begin errors++;
      $display("FAIL reset_strobes got %b exp 111", {bus.ADS_n, bus.RD_n, bus.WR_n}); end
    checks++; if ({bus.breq_o, bus.D_oe, bus.cpu_ack, bus.cpu_err} !== 4'b0000) begin errors++;
      $display("FAIL reset_ctl got %b exp 0000", {bus.breq_o, bus.D_oe, bus.cpu_ack, bus.cpu_err}); end
    checks++; if ({bus.addr, bus.D_o, bus.cpu_rdata} !== 28'h0) begin errors++;
      $display("FAIL reset_data got %h exp 0", {bus.addr, bus.D_o, bus.cpu_rdata}); end
    checks++; if (bus.enout !== 1'b1) begin errors++;
      $display("FAIL reset_enout got %b exp 1", bus.enout); end
    rst_n = 1'b1;
  endtask

  task automatic test_read;
    bus.D_i = 8'h5A;
    start(1'b0, 16'h3123, 4'b0001, 8'h00);
    watch(9, 1, 1, 2, 0, 8'h00, 1'b0);  // hold high during REQ/ADDR must be ignored
    checks++; if (ads_cnt != 1 || ads_first != 2) begin errors++;
      $display("FAIL read_ads got cnt=%0d cyc=%0d exp 1/2", ads_cnt, ads_first); end
    checks++; if (ads_addr !== 12'h123 || ads_do !== 8'h13 || ads_doe !== 1'b1) begin errors++;
      $display("FAIL read_ads_pins got %h/%h/%b exp 123/13/1", ads_addr, ads_do, ads_doe); end
    checks++; if (rd_cnt != 2 || rd_doe_bad != 0 || wr_cnt != 0) begin errors++;
      $display("FAIL read_rd got rd=%0d doe_bad=%0d wr=%0d exp 2/0/0", rd_cnt, rd_doe_bad, wr_cnt); end
    checks++; if (ack_cnt != 1 || ack_first != 5) begin errors++;
      $display("FAIL read_ack got cnt=%0d cyc=%0d exp 1/5", ack_cnt, ack_first); end
    checks++; if (rdata_at_ack !== 8'h5A || bus.cpu_rdata !== 8'h5A) begin errors++;
      $display("FAIL read_rdata got %h/%h exp 5a", rdata_at_ack, bus.cpu_rdata); end
    checks++; if (bus.breq_o !== 1'b0 || bus.enout !== 1'b1) begin errors++;
      $display("FAIL read_release got breq=%b enout=%b exp 0/1", bus.breq_o, bus.enout); end
  endtask

  task automatic test_write_hold;
    start(1'b1, 16'h0040, 4'b1000, 8'hC3);
    watch(12, 1, 4, 6, 0, 8'hC3, 1'b1);
    checks++; if (ads_addr !== 12'h040 || ads_do !== 8'h80) begin errors++;
      $display("FAIL write_ads_pins got %h/%h exp 040/80", ads_addr, ads_do); end
    checks++; if (wr_cnt != 5 || wr_bad != 0 || rd_cnt != 0) begin errors++;
      $display("FAIL write_wr got wr=%0d bad=%0d rd=%0d exp 5/0/0", wr_cnt, wr_bad, rd_cnt); end
    checks++; if (ack_cnt != 1 || ack_first != 8) begin errors++;
      $display("FAIL write_ack got cnt=%0d cyc=%0d exp 1/8", ack_cnt, ack_first); end
  endtask

  task automatic test_enin_wait;
    bus.enin = 1'b0;
    bus.D_i  = 8'hA5;
    start(1'b0, 16'h0200, 4'b0100, 8'h00);
    watch(18, 1, 0, 0, 10, 8'h00, 1'b0);
    checks++; if (ads_cnt != 1 || ads_first != 11) begin errors++;
      $display("FAIL enin_ads got cnt=%0d cyc=%0d exp 1/11", ads_cnt, ads_first); end
    checks++; if (breq_drop != 0 || enout_busy != 0) begin errors++;
      $display("FAIL enin_arb got breq_drop=%0d enout_busy=%0d exp 0/0", breq_drop, enout_busy); end
    checks++; if (ack_first != 14 || rdata_at_ack !== 8'hA5) begin errors++;
      $display("FAIL enin_ack got cyc=%0d rdata=%h exp 14/a5", ack_first, rdata_at_ack); end
  endtask

  task automatic test_back_to_back;
    bus.enin = 1'b1;
    bus.D_i  = 8'h3C;
    @(negedge clk);
    checks++; if (bus.enout !== 1'b1) begin errors++;
      $display("FAIL b2b_idle_enout got %b exp 1", bus.enout); end
    start(1'b0, 16'h0001, 4'b0010, 8'h00);
    watch(14, 2, 0, 0, 0, 8'h00, 1'b0);
    checks++; if (ads_cnt != 2 || ads_first != 2 || ads_last != 6) begin errors++;
      $display("FAIL b2b_ads got cnt=%0d first=%0d last=%0d exp 2/2/6", ads_cnt, ads_first, ads_last); end
    checks++; if (ack_cnt != 2 || ack_first != 5 || ack_last != 9) begin errors++;
      $display("FAIL b2b_ack got cnt=%0d first=%0d last=%0d exp 2/5/9", ack_cnt, ack_first, ack_last); end
    checks++; if (breq_drop != 0 || enout_busy != 0 || bus.breq_o !== 1'b0) begin errors++;
      $display("FAIL b2b_arb got drop=%0d enout_busy=%0d breq_end=%b exp 0/0/0", breq_drop, enout_busy, bus.breq_o); end
  endtask

  task automatic test_reset_mid;
    start(1'b0, 16'h0123, 4'b0000, 8'h00);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    checks++; if (bus.RD_n !== 1'b0) begin errors++;
      $display("FAIL rstmid_pre got RD_n=%b exp 0", bus.RD_n); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({bus.ADS_n, bus.RD_n, bus.WR_n, bus.breq_o, bus.cpu_ack} !== 5'b11100) begin errors++;
      $display("FAIL rstmid_abort got %b exp 11100", {bus.ADS_n, bus.RD_n, bus.WR_n, bus.breq_o, bus.cpu_ack}); end
    rst_n = 1'b1;
    bus.cpu_req = 1'b0;
    watch(5, 1, 0, 0, 0, 8'h00, 1'b0);
    checks++; if (ack_cnt != 0 || ads_cnt != 0 || rd_cnt != 0) begin errors++;
      $display("FAIL rstmid_after got ack=%0d ads=%0d rd=%0d exp 0/0/0", ack_cnt, ads_cnt, rd_cnt); end
  endtask

`ifdef SCMP_BUS_TIMEOUT_EN
  task automatic test_timeout;
    bus.D_i = 8'h11;
    start(1'b0, 16'h0300, 4'b0000, 8'h00);
    watch(12, 1, 1, 100, 0, 8'h00, 1'b0);
    bus.hold = 1'b0;
    checks++; if (ack_cnt != 1 || ack_first != 9 || err_at_ack !== 1'b1) begin errors++;
      $display("FAIL timeout_ack got cnt=%0d cyc=%0d err=%b exp 1/9/1", ack_cnt, ack_first, err_at_ack); end
    checks++; if (rdata_at_ack !== 8'hFF) begin errors++;
      $display("FAIL timeout_rdata got %h exp ff", rdata_at_ack); end
  endtask
`endif

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_flags = '0;
    bus.cpu_wdata = '0; bus.enin = 1'b1; bus.hold = 1'b0; bus.D_i = '0;
    test_reset;
    test_read;
    test_write_hold;
    test_enin_wait;
    test_back_to_back;
    test_reset_mid;
`ifdef SCMP_BUS_TIMEOUT_EN
    test_timeout;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
